// File: rtl/alu.sv
// +------------------------------------------------------------------+
// | Module   : alu                                                   |
// | Function : ADD/SUB/AND/OR with {N,Z,C,V} flags, plus registered  |
// |            copies of result and flags.                           |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
`default_nettype none

module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       control,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [WIDTH-1:0] result_q,
  output logic [3:0]       flags_q
);

  localparam logic [1:0] c_OP_ADD = 2'b00;
  localparam logic [1:0] c_OP_SUB = 2'b01;
  localparam logic [1:0] c_OP_AND = 2'b10;
  localparam logic [1:0] c_OP_OR  = 2'b11;

  logic [WIDTH:0]   w_ext;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_neg;
  logic             w_zero;

  // Arithmetic runs one bit wider so the top bit is carry-out on ADD and borrow on SUB.
  always_comb begin
    w_ext    = '0;
    w_result = '0;
    w_carry  = 1'b0;
    case (control)
      c_OP_ADD: begin
        w_ext    = {1'b0, a} + {1'b0, b};
        w_result = w_ext[WIDTH-1:0];
        w_carry  = w_ext[WIDTH];
      end
      c_OP_SUB: begin
        w_ext    = {1'b0, a} - {1'b0, b};
        w_result = w_ext[WIDTH-1:0];
        w_carry  = w_ext[WIDTH];
      end
      c_OP_AND: w_result = a & b;
      c_OP_OR:  w_result = a | b;
      default: begin
        w_ext    = '0;
        w_result = '0;
        w_carry  = 1'b0;
      end
    endcase
  end

  assign w_neg  = w_result[WIDTH-1];
  assign w_zero = (w_result == '0);

  // V deliberately mirrors C: it flags unsigned overflow/underflow, not signed overflow.
  assign result = w_result;
  assign flags  = {w_neg, w_zero, w_carry, w_carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= 4'b0000;
    end else begin
      result_q <= result;
      flags_q  <= flags;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// +------------------------------------------------------------------+
// | Module   : tb_alu                                                |
// | Function : Scoreboard bench for alu: directed + random vectors.  |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
`default_nettype none

module tb_alu;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       control;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [3:0]       fl;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  alu #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .control  (control),
    .result   (result),
    .flags    (flags),
    .result_q (result_q),
    .flags_q  (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model using 64-bit arithmetic and direct unsigned compare for borrow.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic [1:0] op);
    exp_t        e;
    logic [63:0] wide;
    logic        c;
    c = 1'b0;
    case (op)
      2'b00: begin
        wide  = {32'd0, x} + {32'd0, y};
        e.res = wide[31:0];
        c     = (wide > 64'h0000_0000_FFFF_FFFF);
      end
      2'b01: begin
        e.res = x - y;
        c     = (x < y);
      end
      2'b10: e.res = x & y;
      default: e.res = x | y;
    endcase
    e.fl = {e.res[31], (e.res == 32'd0), c, c};
    return e;
  endfunction

  task automatic drive_now(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic [1:0] op, input logic [WIDTH-1:0] er,
                           input logic [3:0] ef);
    exp_t e;
    a       = x;
    b       = y;
    control = op;
    e.res   = er;
    e.fl    = ef;
    exp_q.push_back(e);
  endtask

  task automatic apply(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic [1:0] op, input logic [WIDTH-1:0] er,
                       input logic [3:0] ef);
    @(negedge clk);
    drive_now(x, y, op, er, ef);
  endtask

  // Monitor: inputs are held from the preceding falling edge, so combinational
  // outputs and the freshly loaded registers must both match the queued entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("result",   result,          e.res);
        chk("flags",    {28'd0, flags},   {28'd0, e.fl});
        chk("result_q", result_q,        e.res);
        chk("flags_q",  {28'd0, flags_q}, {28'd0, e.fl});
      end
    end
  end

  initial begin
    exp_t e;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [1:0]       rc;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b1;
    a       = 32'h0000_0005;
    b       = 32'h0000_0003;
    control = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_result_q", result_q, 32'd0);
    chk("reset_flags_q",  {28'd0, flags_q}, 32'd0);
    chk("reset_comb_result", result, 32'h0000_0008);
    @(posedge clk);
    #1;
    chk("reset_hold_result_q", result_q, 32'd0);

    // Release reset together with the first vector; first edge must load it.
    @(negedge clk);
    rst_n = 1'b1;
    drive_now(32'h0000_0005, 32'h0000_0003, 2'b00, 32'h0000_0008, 4'b0000);

    apply(32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 32'h0000_0000, 4'b0111);
    apply(32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 32'h8000_0000, 4'b1000);
    apply(32'h0000_0001, 32'h0000_0002, 2'b01, 32'hFFFF_FFFF, 4'b1011);
    apply(32'h0000_1234, 32'h0000_1234, 2'b01, 32'h0000_0000, 4'b0100);
    apply(32'h0000_0005, 32'h0000_0003, 2'b01, 32'h0000_0002, 4'b0000);
    apply(32'h0000_0000, 32'h0000_0001, 2'b01, 32'hFFFF_FFFF, 4'b1011);
    apply(32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b10, 32'h00F0_00F0, 4'b0000);
    apply(32'hFFFF_0000, 32'h0000_FFFF, 2'b10, 32'h0000_0000, 4'b0100);
    apply(32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b11, 32'hFFF0_FFF0, 4'b1000);
    apply(32'h0000_0000, 32'h0000_0000, 2'b11, 32'h0000_0000, 4'b0100);
    apply(32'h8000_0000, 32'h8000_0000, 2'b00, 32'h0000_0000, 4'b0111);

    // Asynchronous reset between edges: registers clear at once, comb path untouched.
    apply(32'h0000_0005, 32'h0000_0003, 2'b00, 32'h0000_0008, 4'b0000);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrun_result_q",   result_q, 32'd0);
    chk("midrun_flags_q",    {28'd0, flags_q}, 32'd0);
    chk("midrun_comb_result", result, 32'h0000_0008);
    chk("midrun_comb_flags", {28'd0, flags}, 32'd0);
    @(posedge clk);
    #1;
    chk("midrun_hold_result_q", result_q, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_now(32'h0000_0001, 32'h0000_0002, 2'b01, 32'hFFFF_FFFF, 4'b1011);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 2'($urandom_range(0, 3));
      e  = model(ra, rb, rc);
      apply(ra, rb, rc, e.res, e.fl);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
